// File: rtl/otter_trap_ctrl.sv
// M-mode trap controller: takes exceptions and the external interrupt, commits the trap CSRs,
// services MRET and offers the new fetch PC through a valid/ack redirect handshake.
module otter_trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned IRQ_CAUSE   = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_req,
  input  logic [3:0]  trap_cause,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_val,
  input  logic        irq,
  input  logic        mret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] IRQ_CAUSE_W = IRQ_CAUSE;
  localparam logic [31:0] IRQ_MCAUSE  = {1'b1, IRQ_CAUSE_W[30:0]};
  localparam logic [31:0] IRQ_OFFSET  = {IRQ_CAUSE_W[29:0], 2'b00};

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_t;

  state_t      state, state_next;
  logic        mstatus_mie, mstatus_mpie, mie_meie;
  logic [31:0] mtvec, mepc, mcause, mtval;
  logic [31:0] lat_cause, lat_epc, lat_val;
  logic        lat_irq;
  logic        irq_pending;
  logic        take_trap, take_irq, take_mret, take_csr;
  logic [31:0] commit_target;

  assign irq_pending = mstatus_mie & mie_meie & irq;
  assign take_trap   = (state == IDLE) & trap_req;
  assign take_irq    = (state == IDLE) & ~trap_req & irq_pending;
  assign take_mret   = (state == IDLE) & ~trap_req & ~irq_pending & mret;
  assign take_csr    = (state == IDLE) & ~trap_req & ~irq_pending & ~mret & csr_we;

  assign busy           = (state != IDLE);
  assign redirect_valid = (state == REDIRECT);

  // Vectored mode only relocates interrupts; exceptions always land on the base.
  always_comb begin
    commit_target = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == 2'b01 && lat_irq) commit_target = {mtvec[31:2], 2'b00} + IRQ_OFFSET;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_trap || take_irq) state_next = COMMIT;
        else if (take_mret)        state_next = REDIRECT;
      end
      COMMIT:   state_next = REDIRECT;
      REDIRECT: if (redirect_ack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cause <= '0;
      lat_epc   <= '0;
      lat_val   <= '0;
      lat_irq   <= 1'b0;
    end else if (take_trap) begin
      lat_cause <= {28'b0, trap_cause};
      lat_epc   <= trap_pc;
      lat_val   <= trap_val;
      lat_irq   <= 1'b0;
    end else if (take_irq) begin
      lat_cause <= IRQ_MCAUSE;
      lat_epc   <= trap_pc;
      lat_val   <= '0;
      lat_irq   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec        <= MTVEC_RESET;
      mepc         <= '0;
      mcause       <= '0;
      mtval        <= '0;
      redirect_pc  <= '0;
    end else if (state == COMMIT) begin
      mepc         <= {lat_epc[31:2], 2'b00};
      mcause       <= lat_cause;
      mtval        <= lat_val;
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
      redirect_pc  <= commit_target;
    end else if (take_mret) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
      redirect_pc  <= mepc;
    end else if (take_csr) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatus_mie  <= csr_wdata[3];
          mstatus_mpie <= csr_wdata[7];
        end
        ADDR_MIE:    mie_meie <= csr_wdata[11];
        // Reserved modes 2/3 collapse to direct mode.
        ADDR_MTVEC:  mtvec <= {csr_wdata[31:2], (csr_wdata[1] ? 2'b00 : csr_wdata[1:0])};
        ADDR_MEPC:   mepc <= {csr_wdata[31:2], 2'b00};
        ADDR_MCAUSE: mcause <= csr_wdata;
        ADDR_MTVAL:  mtval <= csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      ADDR_MIE:     csr_rdata = {20'b0, mie_meie, 11'b0};
      ADDR_MTVEC:   csr_rdata = mtvec;
      ADDR_MEPC:    csr_rdata = mepc;
      ADDR_MCAUSE:  csr_rdata = mcause;
      ADDR_MTVAL:   csr_rdata = mtval;
      ADDR_MIP:     csr_rdata = {20'b0, irq, 11'b0};
      default:      csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_otter_trap_ctrl.sv
// Directed bench for otter_trap_ctrl: trap entry, vectored interrupt, MRET, priority,
// redirect back-pressure and asynchronous reset mid-sequence.
module tb_otter_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trap_req;
  logic [3:0]  trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_val;
  logic        irq;
  logic        mret;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;

  int checks = 0;
  int errors = 0;

  otter_trap_ctrl #(.MTVEC_RESET(32'h0000_0000), .IRQ_CAUSE(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_val(trap_val),
    .irq(irq), .mret(mret),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    csr_we    = 1'b1;
    csr_addr  = addr;
    csr_wdata = data;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic ack_redirect();
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; trap_req = 1'b0; trap_cause = '0; trap_pc = '0; trap_val = '0;
    irq = 1'b0; mret = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    redirect_ack = 1'b0;
    #2;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_rvalid", {31'b0, redirect_valid}, 32'd0);
    check("rst_rpc", redirect_pc, 32'h0);
    check_csr("rst_mstatus", 12'h300, 32'h0000_1800);
    check_csr("rst_mtvec", 12'h305, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // CSR write side effects
    csr_write(12'h305, 32'h0000_0302);
    check_csr("mtvec_mode_reserved", 12'h305, 32'h0000_0300);
    csr_write(12'h341, 32'h0000_0123);
    check_csr("mepc_align", 12'h341, 32'h0000_0120);
    check_csr("unmapped", 12'h7C0, 32'h0);

    // Test 1: plain exception
    csr_write(12'h305, 32'h0000_0100);
    csr_write(12'h300, 32'h0000_0008);
    check_csr("t1_mstatus_pre", 12'h300, 32'h0000_1808);
    trap_req = 1'b1; trap_cause = 4'd0; trap_pc = 32'h40; trap_val = 32'h46;
    tick();
    trap_req = 1'b0;
    check("t1_busy_commit", {31'b0, busy}, 32'd1);
    check("t1_rvalid_commit", {31'b0, redirect_valid}, 32'd0);
    tick();
    check("t1_rvalid", {31'b0, redirect_valid}, 32'd1);
    check("t1_rpc", redirect_pc, 32'h100);
    check_csr("t1_mepc", 12'h341, 32'h40);
    check_csr("t1_mcause", 12'h342, 32'h0);
    check_csr("t1_mtval", 12'h343, 32'h46);
    check_csr("t1_mstatus", 12'h300, 32'h0000_1880);
    ack_redirect();
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    check("t1_rvalid_after", {31'b0, redirect_valid}, 32'd0);

    // Test 2: vectored external interrupt
    csr_write(12'h300, 32'h0000_0008);
    csr_write(12'h304, 32'h0000_0800);
    csr_write(12'h305, 32'h0000_0201);
    check_csr("t2_mtvec", 12'h305, 32'h0000_0201);
    check_csr("t2_mip_low", 12'h344, 32'h0);
    irq = 1'b1; trap_pc = 32'h80;
    check_csr("t2_mip_high", 12'h344, 32'h0000_0800);
    tick();
    irq = 1'b0;
    tick();
    check("t2_rvalid", {31'b0, redirect_valid}, 32'd1);
    check("t2_rpc", redirect_pc, 32'h0000_022C);
    check_csr("t2_mcause", 12'h342, 32'h8000_000B);
    check_csr("t2_mepc", 12'h341, 32'h80);
    check_csr("t2_mtval", 12'h343, 32'h0);
    check_csr("t2_mstatus", 12'h300, 32'h0000_1880);

    // Test 5: redirect held without ack, trap pulses while busy are ignored
    for (int i = 0; i < 5; i++) begin
      trap_req = (i == 1 || i == 3); trap_cause = 4'd2; trap_pc = 32'h999; trap_val = 32'h77;
      tick();
      check("t5_rvalid_hold", {31'b0, redirect_valid}, 32'd1);
      check("t5_rpc_hold", redirect_pc, 32'h0000_022C);
    end
    trap_req = 1'b0;
    ack_redirect();
    check("t5_busy_after", {31'b0, busy}, 32'd0);
    check_csr("t5_mcause_kept", 12'h342, 32'h8000_000B);
    check_csr("t5_mepc_kept", 12'h341, 32'h80);

    // Test 4: MRET returns to mepc one cycle after acceptance, ack in first cycle
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("t4_rvalid", {31'b0, redirect_valid}, 32'd1);
    check("t4_rpc", redirect_pc, 32'h80);
    check_csr("t4_mstatus", 12'h300, 32'h0000_1888);
    ack_redirect();
    check("t4_busy_after", {31'b0, busy}, 32'd0);

    // Test 3: exception beats pending interrupt; same-cycle csr_we dropped
    irq = 1'b1; trap_req = 1'b1; trap_cause = 4'd2; trap_pc = 32'h120; trap_val = 32'hDEAD;
    csr_we = 1'b1; csr_addr = 12'h304; csr_wdata = 32'h0;
    tick();
    trap_req = 1'b0; irq = 1'b0; csr_we = 1'b0;
    tick();
    check("t3_rpc", redirect_pc, 32'h200);
    check_csr("t3_mcause", 12'h342, 32'h2);
    check_csr("t3_mepc", 12'h341, 32'h120);
    check_csr("t3_mtval", 12'h343, 32'hDEAD);
    check_csr("t3_mstatus", 12'h300, 32'h0000_1880);
    check_csr("t3_mie_kept", 12'h304, 32'h0000_0800);
    ack_redirect();

    // Test 6: asynchronous reset while in COMMIT
    trap_req = 1'b1; trap_cause = 4'd4; trap_pc = 32'h44; trap_val = 32'h55;
    tick();
    trap_req = 1'b0;
    check("t6_busy_commit", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_rvalid", {31'b0, redirect_valid}, 32'd0);
    check("t6_rpc", redirect_pc, 32'h0);
    check_csr("t6_mepc", 12'h341, 32'h0);
    check_csr("t6_mtvec", 12'h305, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_busy_post", {31'b0, busy}, 32'd0);
    check_csr("t6_mepc_post", 12'h341, 32'h0);
    check_csr("t6_mcause_post", 12'h342, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
